// File: rtl/adpll_gain_scheduler.sv
// ADPLL loop-filter gain scheduler: steps kp/ki from acquisition to
// tracking gains and flags lock after sustained small phase error.
module adpll_gain_scheduler #(
  parameter int ERROR_WIDTH   = 5,
  parameter int KP_WIDTH      = 5,
  parameter int KI_WIDTH      = 7,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 5'd8,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 7'd16,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 5'd2,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 7'd2,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 6,
  parameter int ACQ_COUNT     = 16,
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_COUNT  = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   sample_valid_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic [KP_WIDTH-1:0]    kp_o,
  output logic [KI_WIDTH-1:0]    ki_o,
  output logic                   lock_o,
  output logic                   gain_update_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam int MW = ERROR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] ACQ_LAST =
    CNT_WIDTH'(ACQ_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST =
    CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST =
    CNT_WIDTH'(UNLOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  state_e                state_q;
  logic [KP_WIDTH-1:0]   kp_q;
  logic [KI_WIDTH-1:0]   ki_q;
  logic                  lock_q;
  logic                  upd_q;
  logic [CNT_WIDTH-1:0]  in_cnt_q;
  logic [CNT_WIDTH-1:0]  out_cnt_q;

  // One extra bit so the most-negative error has a representable magnitude.
  logic [MW-1:0] err_ext;
  logic [MW-1:0] err_mag;
  logic          in_band;
  logic          out_band;

  always_comb begin
    err_ext  = {error_i[ERROR_WIDTH-1], error_i};
    err_mag  = err_ext[MW-1] ? (~err_ext + MW'(1)) : err_ext;
    in_band  = err_mag <= MW'(LOCK_THRESH);
    out_band = err_mag >  MW'(UNLOCK_THRESH);
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      kp_q      <= '0;
      ki_q      <= '0;
      lock_q    <= 1'b0;
      upd_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      upd_q <= 1'b0;
      if (!enable_i) begin
        if (state_q != IDLE) begin
          state_q <= IDLE;
          kp_q    <= '0;
          ki_q    <= '0;
          lock_q  <= 1'b0;
          upd_q   <= 1'b1;
        end
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= ACQUIRE;
            kp_q      <= KP_ACQ;
            ki_q      <= KI_ACQ;
            upd_q     <= 1'b1;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
          ACQUIRE: begin
            if (sample_valid_i) begin
              if (!in_band) begin
                in_cnt_q <= '0;
              end else if (in_cnt_q == ACQ_LAST) begin
                state_q  <= TRACK;
                kp_q     <= KP_TRK;
                ki_q     <= KI_TRK;
                upd_q    <= 1'b1;
                in_cnt_q <= '0;
              end else begin
                in_cnt_q <= in_cnt_q + CNT_ONE;
              end
            end
          end
          TRACK: begin
            if (sample_valid_i) begin
              unique case (1'b1)
                out_band: begin
                  state_q  <= ACQUIRE;
                  kp_q     <= KP_ACQ;
                  ki_q     <= KI_ACQ;
                  upd_q    <= 1'b1;
                  in_cnt_q <= '0;
                end
                in_band: begin
                  if (in_cnt_q == LOCK_LAST) begin
                    state_q  <= LOCKED;
                    lock_q   <= 1'b1;
                    in_cnt_q <= '0;
                  end else begin
                    in_cnt_q <= in_cnt_q + CNT_ONE;
                  end
                end
                default: in_cnt_q <= '0;
              endcase
            end
          end
          LOCKED: begin
            if (sample_valid_i) begin
              if (!out_band) begin
                out_cnt_q <= '0;
              end else if (out_cnt_q == UNLOCK_LAST) begin
                state_q   <= ACQUIRE;
                lock_q    <= 1'b0;
                kp_q      <= KP_ACQ;
                ki_q      <= KI_ACQ;
                upd_q     <= 1'b1;
                out_cnt_q <= '0;
              end else begin
                out_cnt_q <= out_cnt_q + CNT_ONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign kp_o          = kp_q;
  assign ki_o          = ki_q;
  assign lock_o        = lock_q;
  assign gain_update_o = upd_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Bench for adpll_gain_scheduler: directed gear-shift sequences then
// random error streams, checked against an arithmetic reference model.
module tb_adpll_gain_scheduler;

  logic       gen_clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       sample_valid_i;
  logic [4:0] error_i;
  logic [4:0] kp_o;
  logic [6:0] ki_o;
  logic       lock_o;
  logic       gain_update_o;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  logic [1:0] m_state;
  logic [4:0] m_kp;
  logic [6:0] m_ki;
  logic       m_lock;
  logic       m_upd;
  int         m_in;
  int         m_out;

  adpll_gain_scheduler dut (
    .gen_clk_i      (gen_clk_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .sample_valid_i (sample_valid_i),
    .error_i        (error_i),
    .kp_o           (kp_o),
    .ki_o           (ki_o),
    .lock_o         (lock_o),
    .gain_update_o  (gain_update_o),
    .state_o        (state_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  task automatic model_reset();
    m_state = 2'd0; m_kp = 5'd0; m_ki = 7'd0;
    m_lock = 1'b0; m_upd = 1'b0; m_in = 0; m_out = 0;
  endtask

  task automatic go_acq();
    m_state = 2'd1; m_kp = 5'd8; m_ki = 7'd16; m_upd = 1'b1;
    m_in = 0; m_out = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int e);
    int a;
    a = (e < 0) ? -e : e;
    m_upd = 1'b0;
    if (!en) begin
      if (m_state != 2'd0) begin
        m_state = 2'd0; m_kp = 5'd0; m_ki = 7'd0;
        m_lock = 1'b0; m_upd = 1'b1;
      end
      m_in = 0; m_out = 0;
      return;
    end
    case (m_state)
      2'd0: go_acq();
      2'd1: if (v) begin
        if (a <= 2) begin
          m_in++;
          if (m_in == 16) begin
            m_state = 2'd2; m_kp = 5'd2; m_ki = 7'd2;
            m_upd = 1'b1; m_in = 0;
          end
        end else m_in = 0;
      end
      2'd2: if (v) begin
        if (a > 6) go_acq();
        else if (a <= 2) begin
          m_in++;
          if (m_in == 32) begin
            m_state = 2'd3; m_lock = 1'b1; m_in = 0;
          end
        end else m_in = 0;
      end
      default: if (v) begin
        if (a > 6) begin
          m_out++;
          if (m_out == 4) begin
            go_acq(); m_lock = 1'b0;
          end
        end else m_out = 0;
      end
    endcase
  endtask

  task automatic check(input string tag);
    checks++;
    assert (state_o === m_state) else begin
      errors++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state_o, m_state);
    end
    checks++;
    assert (kp_o === m_kp) else begin
      errors++;
      $error("FAIL %s kp obs=%0d exp=%0d", tag, kp_o, m_kp);
    end
    checks++;
    assert (ki_o === m_ki) else begin
      errors++;
      $error("FAIL %s ki obs=%0d exp=%0d", tag, ki_o, m_ki);
    end
    checks++;
    assert (lock_o === m_lock) else begin
      errors++;
      $error("FAIL %s lock obs=%0b exp=%0b", tag, lock_o, m_lock);
    end
    checks++;
    assert (gain_update_o === m_upd) else begin
      errors++;
      $error("FAIL %s upd obs=%0b exp=%0b", tag, gain_update_o, m_upd);
    end
  endtask

  task automatic tick(input bit en, input bit v, input int e,
                      input string tag);
    enable_i       = en;
    sample_valid_i = v;
    error_i        = 5'(e);
    @(posedge gen_clk_i);
    model_step(en, v, e);
    #1;
    check(tag);
  endtask

  task automatic samples(input int n, input int e, input string tag);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, e, tag);
  endtask

  task automatic gap_sample(input int e, input string tag);
    tick(1'b1, 1'b0, 0, {tag, "_gap"});
    tick(1'b1, 1'b1, e, tag);
  endtask

  initial begin
    int e;
    bit v;
    bit en;
    reset_i = 1'b1;
    enable_i = 1'b0;
    sample_valid_i = 1'b0;
    error_i = 5'd0;
    model_reset();
    #12;
    check("reset");
    @(negedge gen_clk_i);
    reset_i = 1'b0;

    tick(1'b1, 1'b0, 0, "enable");
    tick(1'b1, 1'b0, 0, "enable_hold");

    samples(15, 1, "acq_in");
    samples(1, -3, "acq_break");
    samples(16, -2, "acq_to_trk");

    samples(31, 0, "trk_in");
    samples(1, 4, "trk_mid");
    samples(32, 0, "trk_to_lock");

    for (int i = 0; i < 3; i++) gap_sample(-7, "lk_out");
    gap_sample(0, "lk_clear");
    for (int i = 0; i < 4; i++) gap_sample(-16, "lk_unlock");

    samples(16, 0, "reacq");
    samples(1, 7, "trk_fall");

    samples(16, 0, "acq2");
    samples(32, 0, "lock2");
    tick(1'b0, 1'b1, 0, "disable");
    tick(1'b0, 1'b1, 0, "idle_hold");

    tick(1'b1, 1'b0, 0, "enable2");
    samples(16, 0, "acq3");
    samples(32, 0, "lock3");
    @(posedge gen_clk_i);
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    check("async_reset");
    @(negedge gen_clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(199) != 0);
      v  = ($urandom_range(3) != 0);
      if ($urandom_range(9) < 8)
        e = $urandom_range(4) - 2;
      else
        e = $urandom_range(31) - 16;
      tick(en, v, e, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
